// File: rtl/uart_frame_packer_if.sv
// Sample stream and UART-transmitter handshake bundle for uart_frame_packer.
// The packer connects through the slave modport; the environment that feeds
// samples and owns the transmitter busy flag uses the master modport.
interface uart_frame_packer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_ready;
    logic              o_tx_start;
    logic [7:0]        o_tx_data;
    logic              i_tx_busy;
    logic              o_busy;
    logic              o_frame_done;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_tx_busy,
        output o_ready,
        output o_tx_start,
        output o_tx_data,
        output o_busy,
        output o_frame_done
    );

    modport master (
        output i_valid,
        output i_data,
        output i_tx_busy,
        input  o_ready,
        input  o_tx_start,
        input  o_tx_data,
        input  o_busy,
        input  o_frame_done
    );
endinterface

// File: rtl/uart_frame_packer.sv
// Wraps every FRAME_LEN samples in a frame: HDR0, HDR1, payload bytes
// (each sample MSB byte first) and an 8-bit modular sum of the payload.
// Bytes go out one at a time over the UART start/data/busy handshake.
//
// state  | meaning
// S_IDLE | no frame open, waiting for the first sample
// S_HDR0 | sending the first header byte
// S_HDR1 | sending the second header byte
// S_DATA | sending the bytes of the held sample
// S_LOAD | mid-frame, waiting for the next sample
// S_CSUM | sending the checksum byte
//
// Each sending state steps through ISSUE (start pulse, only while the
// transmitter is idle), GAP (busy ignored while the transmitter raises it)
// and WAIT (hold until busy falls).
module uart_frame_packer #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned DATA_W    = 32,
    parameter logic [7:0]  HDR0      = 8'hAA,
    parameter logic [7:0]  HDR1      = 8'h55
) (
    input logic i_clk,
    input logic i_rst,
    uart_frame_packer_if.slave bus
);
    localparam int unsigned BYTES     = DATA_W / 8;
    localparam logic [1:0]  LAST_IDX  = 2'(BYTES - 1);
    localparam logic [15:0] LAST_SAMP = 16'(FRAME_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_LOAD,
        S_CSUM
    } state_t;

    typedef enum logic [1:0] {
        P_ISSUE,
        P_GAP,
        P_WAIT
    } phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              done_q, done_d;

    logic              ready;
    logic              xfer;
    logic              tx_start;
    logic [4:0]        shamt;
    logic [7:0]        data_byte;
    logic [7:0]        cur_byte;

    assign ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign xfer  = bus.i_valid && ready;

    // Select the payload byte for the current index, most significant first.
    always_comb begin
        shamt     = {LAST_IDX - idx_q, 3'b000};
        data_byte = hold_q[shamt +: 8];
    end

    // Byte presented to the transmitter for whichever sending state is active.
    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            S_HDR0:  cur_byte = HDR0;
            S_HDR1:  cur_byte = HDR1;
            S_DATA:  cur_byte = data_byte;
            S_CSUM:  cur_byte = csum_q;
            default: cur_byte = 8'h00;
        endcase
    end

    // Next-state, datapath updates and the start pulse.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
        tx_start  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    hold_d  = bus.i_data;
                    csum_d  = 8'h00;
                    cnt_d   = 16'd1;
                    idx_d   = 2'd0;
                    phase_d = P_ISSUE;
                    state_d = S_HDR0;
                end
            end

            S_LOAD: begin
                if (xfer) begin
                    hold_d  = bus.i_data;
                    cnt_d   = cnt_q + 16'd1;
                    idx_d   = 2'd0;
                    phase_d = P_ISSUE;
                    state_d = S_DATA;
                end
            end

            default: begin
                case (phase_q)
                    P_ISSUE: begin
                        // Also covers a transmitter still busy with an older byte.
                        if (!bus.i_tx_busy) begin
                            tx_start  = 1'b1;
                            tx_data_d = cur_byte;
                            if (state_q == S_DATA) begin
                                csum_d = csum_q + cur_byte;
                            end
                            phase_d = P_GAP;
                        end
                    end

                    P_GAP: begin
                        phase_d = P_WAIT;
                    end

                    default: begin
                        if (!bus.i_tx_busy) begin
                            phase_d = P_ISSUE;
                            case (state_q)
                                S_HDR0: state_d = S_HDR1;
                                S_HDR1: begin
                                    idx_d   = 2'd0;
                                    state_d = S_DATA;
                                end
                                S_DATA: begin
                                    if (idx_q == LAST_IDX) begin
                                        state_d = (cnt_q == LAST_SAMP) ? S_CSUM : S_LOAD;
                                    end else begin
                                        idx_d = idx_q + 2'd1;
                                    end
                                end
                                S_CSUM: begin
                                    done_d  = 1'b1;
                                    state_d = S_IDLE;
                                end
                                default: state_d = S_IDLE;
                            endcase
                        end
                    end
                endcase
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            phase_q   <= P_ISSUE;
            hold_q    <= '0;
            cnt_q     <= 16'd0;
            idx_q     <= 2'd0;
            csum_q    <= 8'h00;
            tx_data_q <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
        end
    end

    // The new byte is visible in the start cycle and held until the next start.
    assign bus.o_tx_start   = tx_start;
    assign bus.o_tx_data    = tx_start ? cur_byte : tx_data_q;
    assign bus.o_ready      = ready;
    assign bus.o_busy       = (state_q != S_IDLE);
    assign bus.o_frame_done = done_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Four packer lanes with different FRAME_LEN/DATA_W, each driven by the bench
// and paired with a simple transmitter busy model. Received bytes are checked
// against frames built from the offered samples.
module tb_uart_frame_packer;
    localparam int FL [4] = '{2, 3, 1, 1};
    localparam int DW [4] = '{32, 32, 32, 8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       rst_r, valid_r, busy_r, force_busy, inc_mode;
    logic [3:0][31:0] data_r;
    logic [3:0]       ready_w, start_w, done_w, busyo_w;
    logic [3:0][7:0]  txd_w;

    int total = 0;
    int bad   = 0;
    int start_cnt [4];
    int acc_cnt   [4];
    int done_cnt  [4];
    int unsigned busy_left [4];
    logic [3:0]  start_now, acc_now;
    logic [7:0]  last_txd [4];
    logic [7:0]  got_q [4][$];
    logic [31:0] samp_q [$];
    logic [7:0]  exp_q [$];

    for (genvar g = 0; g < 4; g++) begin : gl
        uart_frame_packer_if #(.DATA_W(DW[g])) bus ();
        assign bus.i_valid   = valid_r[g];
        assign bus.i_data    = data_r[g][DW[g]-1:0];
        assign bus.i_tx_busy = busy_r[g];
        assign ready_w[g]    = bus.o_ready;
        assign start_w[g]    = bus.o_tx_start;
        assign txd_w[g]      = bus.o_tx_data;
        assign done_w[g]     = bus.o_frame_done;
        assign busyo_w[g]    = bus.o_busy;
        uart_frame_packer #(
            .FRAME_LEN(FL[g]),
            .DATA_W   (DW[g]),
            .HDR0     (8'hAA),
            .HDR1     (8'h55)
        ) dut (
            .i_clk(clk),
            .i_rst(rst_r[g]),
            .bus  (bus)
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge, then update transmitter model and inputs after posedge.
    task automatic tick();
        @(negedge clk);
        for (int l = 0; l < 4; l++) begin
            acc_now[l]   = 1'b0;
            start_now[l] = 1'b0;
            if (rst_r[l]) begin
                last_txd[l] = 8'h00;
            end else begin
                if (valid_r[l] && ready_w[l]) begin
                    acc_now[l] = 1'b1;
                    acc_cnt[l]++;
                end
                if (start_w[l]) begin
                    start_now[l] = 1'b1;
                    start_cnt[l]++;
                    check($sformatf("L%0d_start_while_busy", l), 32'(busy_r[l]), 32'd0);
                    check($sformatf("L%0d_ready_during_send", l), 32'(ready_w[l]), 32'd0);
                    got_q[l].push_back(txd_w[l]);
                    last_txd[l] = txd_w[l];
                end else begin
                    check($sformatf("L%0d_tx_data_hold", l), 32'(txd_w[l]), 32'(last_txd[l]));
                end
                if (done_w[l]) done_cnt[l]++;
            end
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < 4; l++) begin
            if (start_now[l]) busy_left[l] = $urandom_range(2, 8);
            else if (busy_left[l] != 0) busy_left[l]--;
            busy_r[l] = (busy_left[l] != 0) || force_busy[l];
            if (inc_mode[l] && acc_now[l]) data_r[l] = data_r[l] + 32'd1;
        end
    endtask

    task automatic send_sample(input int l, input logic [31:0] s);
        int k = 0;
        bit got = 1'b0;
        valid_r[l] = 1'b1;
        data_r[l]  = s;
        while (!got && k < 3000) begin
            tick();
            got = acc_now[l];
            k++;
        end
        valid_r[l] = 1'b0;
        check($sformatf("L%0d_sample_accepted", l), 32'(got), 32'd1);
    endtask

    task automatic wait_done(input int l, input int budget);
        int n0 = done_cnt[l];
        int k = 0;
        while (done_cnt[l] == n0 && k < budget) begin
            tick();
            k++;
        end
        check($sformatf("L%0d_frame_done", l), 32'(done_cnt[l] - n0), 32'd1);
        tick();
        tick();
        check($sformatf("L%0d_busy_after_done", l), 32'(busyo_w[l]), 32'd0);
        check($sformatf("L%0d_done_single_pulse", l), 32'(done_cnt[l] - n0), 32'd1);
    endtask

    // Expected frame: header, each sample's bytes high to low, modulo-256 payload sum.
    task automatic compare_frame(input int l);
        logic [7:0] sum;
        logic [7:0] b8;
        int nb;
        exp_q.delete();
        sum = 8'h00;
        nb  = DW[l] / 8;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        foreach (samp_q[i]) begin
            for (int b = nb - 1; b >= 0; b--) begin
                b8 = 8'((samp_q[i] >> (8 * b)) & 32'hFF);
                exp_q.push_back(b8);
                sum = sum + b8;
            end
        end
        exp_q.push_back(sum);
        check($sformatf("L%0d_frame_len", l), 32'(got_q[l].size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q[l].size(); i++) begin
            check($sformatf("L%0d_byte%0d", l, i), 32'(got_q[l][i]), 32'(exp_q[i]));
        end
    endtask

    task automatic random_frame(input int l);
        logic [31:0] s;
        samp_q.delete();
        got_q[l].delete();
        for (int i = 0; i < FL[l]; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            s = $urandom();
            if (DW[l] == 8) s = s & 32'hFF;
            samp_q.push_back(s);
            send_sample(l, s);
        end
        wait_done(l, 3000);
        compare_frame(l);
    endtask

    initial begin
        int s0;
        int k;
        int rl;
        int d0;
        logic [31:0] base;

        rst_r      = 4'hF;
        valid_r    = 4'h0;
        busy_r     = 4'h0;
        force_busy = 4'h0;
        inc_mode   = 4'h0;
        data_r     = '0;
        for (int l = 0; l < 4; l++) begin
            start_cnt[l] = 0;
            acc_cnt[l]   = 0;
            done_cnt[l]  = 0;
            busy_left[l] = 0;
            last_txd[l]  = 8'h00;
        end
        start_now = 4'h0;
        acc_now   = 4'h0;

        repeat (3) tick();
        rst_r = 4'h0;
        for (int l = 0; l < 4; l++) begin
            check($sformatf("L%0d_rst_ready", l), 32'(ready_w[l]), 32'd1);
            check($sformatf("L%0d_rst_start", l), 32'(start_w[l]), 32'd0);
            check($sformatf("L%0d_rst_txdata", l), 32'(txd_w[l]), 32'd0);
            check($sformatf("L%0d_rst_done", l), 32'(done_w[l]), 32'd0);
            check($sformatf("L%0d_rst_busy", l), 32'(busyo_w[l]), 32'd0);
        end

        // Basic two-sample frame with 500-cycle backpressure before the second sample.
        got_q[0].delete();
        samp_q.delete();
        samp_q.push_back(32'h01020304);
        samp_q.push_back(32'hA0B0C0D0);
        s0 = start_cnt[0];
        send_sample(0, 32'h01020304);
        tick();
        check("L0_hdr0_latency", 32'(start_now[0]), 32'd1);
        k = 0;
        while ((start_cnt[0] - s0 < 6 || busy_r[0]) && k < 2000) begin
            tick();
            k++;
        end
        repeat (4) tick();
        s0 = start_cnt[0];
        rl = 0;
        repeat (500) begin
            tick();
            if (!ready_w[0]) rl++;
        end
        check("L0_bp_no_start", 32'(start_cnt[0] - s0), 32'd0);
        check("L0_bp_ready_low_cycles", 32'(rl), 32'd0);
        send_sample(0, 32'hA0B0C0D0);
        wait_done(0, 3000);
        compare_frame(0);
        check("L0_csum_byte", 32'(got_q[0][got_q[0].size() - 1]), 32'hEA);

        // Continuous valid with incrementing data, FRAME_LEN = 3.
        got_q[1].delete();
        samp_q.delete();
        s0   = acc_cnt[1];
        base = $urandom();
        data_r[1]   = base;
        inc_mode[1] = 1'b1;
        valid_r[1]  = 1'b1;
        k = 0;
        while (acc_cnt[1] - s0 < 3 && k < 3000) begin
            tick();
            k++;
        end
        valid_r[1]  = 1'b0;
        inc_mode[1] = 1'b0;
        for (int i = 0; i < 3; i++) samp_q.push_back(base + 32'(i));
        wait_done(1, 3000);
        check("L1_accept_count", 32'(acc_cnt[1] - s0), 32'd3);
        compare_frame(1);

        // Reset during the fifth byte, then a fresh single-sample frame.
        got_q[2].delete();
        s0 = start_cnt[2];
        send_sample(2, $urandom());
        k = 0;
        while (start_cnt[2] - s0 < 5 && k < 2000) begin
            tick();
            k++;
        end
        check("L2_reached_byte5", 32'(start_cnt[2] - s0), 32'd5);
        d0 = done_cnt[2];
        rst_r[2] = 1'b1;
        tick();
        check("L2_mid_rst_ready", 32'(ready_w[2]), 32'd1);
        check("L2_mid_rst_start", 32'(start_w[2]), 32'd0);
        check("L2_mid_rst_txdata", 32'(txd_w[2]), 32'd0);
        check("L2_mid_rst_done", 32'(done_w[2]), 32'd0);
        check("L2_mid_rst_busy", 32'(busyo_w[2]), 32'd0);
        rst_r[2] = 1'b0;
        s0 = start_cnt[2];
        repeat (20) tick();
        check("L2_no_start_after_rst", 32'(start_cnt[2] - s0), 32'd0);
        check("L2_no_done_after_rst", 32'(done_cnt[2] - d0), 32'd0);
        got_q[2].delete();
        samp_q.delete();
        samp_q.push_back(32'h000000FF);
        send_sample(2, 32'h000000FF);
        wait_done(2, 3000);
        compare_frame(2);
        check("L2_csum_byte", 32'(got_q[2][got_q[2].size() - 1]), 32'hFF);

        // Transmitter already busy when the frame opens.
        force_busy[2] = 1'b1;
        tick();
        got_q[2].delete();
        samp_q.delete();
        base = $urandom();
        samp_q.push_back(base);
        send_sample(2, base);
        s0 = start_cnt[2];
        repeat (30) tick();
        check("L2_hold_while_busy", 32'(start_cnt[2] - s0), 32'd0);
        force_busy[2] = 1'b0;
        wait_done(2, 3000);
        compare_frame(2);

        // 8-bit samples, FRAME_LEN = 1.
        got_q[3].delete();
        samp_q.delete();
        samp_q.push_back(32'h80);
        send_sample(3, 32'h80);
        wait_done(3, 3000);
        compare_frame(3);
        check("L3_csum_byte", 32'(got_q[3][got_q[3].size() - 1]), 32'h80);

        // Random frames on every lane.
        for (int r = 0; r < 4; r++) begin
            random_frame(0);
            random_frame(1);
            random_frame(2);
            random_frame(3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
